// File: rtl/matrix_deskew_collector.sv
// -----------------------------------------------------------------------------
// matrix_deskew_collector
//
// Receive end of the systolic datapath. The PE array delivers its results as
// a diagonally skewed stream, with one lane per output column. This block
// undoes that skew and assembles a complete ROWS x COLS result matrix. The
// matrix is then held on a valid/ready output until the consumer takes it.
//
// A beat is a rising edge with in_valid && in_ready. On beat k, lane j is
// stored into matrix_C[k-j][j] when 0 <= k-j <= ROWS-1; every other lane is
// ignored on that beat. A matrix is complete after NBEATS = ROWS+COLS-1 beats.
//
// Parameters:
//   WIDTH  element width in bits
//   ROWS   result matrix rows    (>= 1)
//   COLS   result matrix columns (>= 1), equal to the number of array lanes
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     skewed lane data valid
//   in_ready     collector can accept a beat (low only while a matrix is held)
//   in_data      lane j = array output column j
//   matrix_C     assembled result matrix, registered
//   out_valid    matrix_C complete and stable, registered
//   out_ready    consumer accepts matrix_C
//   busy         capture in progress, registered
//   stall_count  (only with COLLECT_STALL_COUNT_EN) cycles spent waiting for
//                beats in the middle of a capture, saturating at 16'hFFFF
//
// Optional feature macro: COLLECT_STALL_COUNT_EN
// -----------------------------------------------------------------------------
module matrix_deskew_collector #(
    parameter int WIDTH = 32,
    parameter int ROWS  = 2,
    parameter int COLS  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data  [COLS],
    output logic [WIDTH-1:0] matrix_C [ROWS][COLS],
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
`ifdef COLLECT_STALL_COUNT_EN
    ,
    output logic [15:0]      stall_count
`endif
);

    localparam int NBEATS = ROWS + COLS - 1;
    localparam int KW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [KW-1:0] K_ZERO = KW'(32'd0);
    localparam logic [KW-1:0] K_ONE  = KW'(32'd1);
    localparam logic [KW-1:0] K_LAST = KW'(NBEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [KW-1:0]    k_r;
    logic [KW-1:0]    next_k_s;
    logic             beat_s;
    logic             out_valid_r;
    logic             busy_r;
    logic [WIDTH-1:0] matrix_r [ROWS][COLS];

    // Backpressure depends only on the state. While a matrix is held, no beat
    // is taken, even if the consumer accepts it in that same cycle.
    assign in_ready = (state_r != ST_FULL);
    assign beat_s   = in_valid && in_ready;

    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign matrix_C  = matrix_r;

    // Next-state and beat-index logic. The index advances only on beats, so
    // idle input cycles do not disturb the skew alignment.
    always_comb begin
        next_state_s = state_r;
        next_k_s     = k_r;
        case (state_r)
            ST_IDLE: begin
                if (beat_s) begin
                    if (NBEATS == 1) begin
                        next_state_s = ST_FULL;
                        next_k_s     = K_ZERO;
                    end else begin
                        next_state_s = ST_CAPTURE;
                        next_k_s     = K_ONE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                    next_k_s     = K_ZERO;
                end
            end
            ST_CAPTURE: begin
                if (beat_s) begin
                    if (k_r == K_LAST) begin
                        next_state_s = ST_FULL;
                        next_k_s     = K_ZERO;
                    end else begin
                        next_state_s = ST_CAPTURE;
                        next_k_s     = k_r + K_ONE;
                    end
                end else begin
                    next_state_s = ST_CAPTURE;
                    next_k_s     = k_r;
                end
            end
            ST_FULL: begin
                if (out_valid_r && out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FULL;
                end
                next_k_s = K_ZERO;
            end
            default: begin
                next_state_s = ST_IDLE;
                next_k_s     = K_ZERO;
            end
        endcase
    end

    // State, beat index and registered status flags. The flags are decoded
    // from the next state so that they line up with state_r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            k_r         <= K_ZERO;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            k_r         <= next_k_s;
            out_valid_r <= (next_state_s == ST_FULL);
            busy_r      <= (next_state_s == ST_CAPTURE);
        end
    end

    // Matrix storage. Element [r][c] is written only on the beat with
    // k == r + c, so it is written exactly once per matrix. Until then it keeps
    // its value from the previous matrix.
    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!rst_n) begin
                    matrix_r[r][c] <= {WIDTH{1'b0}};
                end else if (beat_s && (k_r == KW'(r + c))) begin
                    matrix_r[r][c] <= in_data[c];
                end
            end
        end
    end

`ifdef COLLECT_STALL_COUNT_EN
    logic [15:0] stall_count_r;

    assign stall_count = stall_count_r;

    // Counts the input bubbles inside one capture. It restarts on the first
    // beat of a new matrix and then holds its value until that point.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_r <= 16'h0000;
        end else if ((state_r == ST_IDLE) && beat_s) begin
            stall_count_r <= 16'h0000;
        end else if ((state_r == ST_CAPTURE) && !in_valid && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_deskew_collector.sv
// Self-checking bench for matrix_deskew_collector: a 2x2 instance with a
// scoreboard, plus 3x1 and 1x1 instances for the degenerate shapes.
module tb_matrix_deskew_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef logic [3:0][31:0] mat_t;
    mat_t exp_q [$];
    mat_t sb_e;

    // 2x2 instance
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [31:0] a_in_data [2];
    logic [31:0] a_mat     [2][2];
    // 3x1 instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [31:0] b_in_data [1];
    logic [31:0] b_mat     [3][1];
    // 1x1 instance
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
    logic [31:0] c_in_data [1];
    logic [31:0] c_mat     [1][1];
`ifdef COLLECT_STALL_COUNT_EN
    logic [15:0] a_stall, b_stall, c_stall;
`endif

    matrix_deskew_collector #(.WIDTH(32), .ROWS(2), .COLS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .matrix_C(a_mat), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .busy(a_busy)
`ifdef COLLECT_STALL_COUNT_EN
        , .stall_count(a_stall)
`endif
    );

    matrix_deskew_collector #(.WIDTH(32), .ROWS(3), .COLS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .matrix_C(b_mat), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .busy(b_busy)
`ifdef COLLECT_STALL_COUNT_EN
        , .stall_count(b_stall)
`endif
    );

    matrix_deskew_collector #(.WIDTH(32), .ROWS(1), .COLS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .matrix_C(c_mat), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .busy(c_busy)
`ifdef COLLECT_STALL_COUNT_EN
        , .stall_count(c_stall)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input logic [31:0] d0, input logic [31:0] d1);
        a_in_valid   = 1'b1;
        a_in_data[0] = d0;
        a_in_data[1] = d1;
        tick();
    endtask

    // Expected matrix, given in order c00, c01, c10, c11
    task automatic expect_a(input logic [31:0] e00, input logic [31:0] e01,
                            input logic [31:0] e10, input logic [31:0] e11);
        exp_q.push_back({e11, e10, e01, e00});
    endtask

    task automatic check_mat_a(input string name, input logic [31:0] e00, input logic [31:0] e01,
                               input logic [31:0] e10, input logic [31:0] e11);
        check({name, "_c00"}, a_mat[0][0], e00);
        check({name, "_c01"}, a_mat[0][1], e01);
        check({name, "_c10"}, a_mat[1][0], e10);
        check({name, "_c11"}, a_mat[1][1], e11);
    endtask

    // Scoreboard monitor: compare on every output handshake of the 2x2 instance
    always @(negedge clk) begin
        if (rst_n === 1'b1 && a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: out_valid=1 with no expected matrix queued");
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_c00", a_mat[0][0], sb_e[0]);
                check("sb_c01", a_mat[0][1], sb_e[1]);
                check("sb_c10", a_mat[1][0], sb_e[2]);
                check("sb_c11", a_mat[1][1], sb_e[3]);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_in_data[0] = 32'd0; a_in_data[1] = 32'd0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data[0] = 32'd0;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_in_data[0] = 32'd0;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", a_out_valid, 32'd0);
        check("rst_busy", a_busy, 32'd0);
        check("rst_in_ready", a_in_ready, 32'd1);
        check_mat_a("rst_mat", 32'd0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;

        // 1: back-to-back beats
        a_out_ready = 1'b1;
        expect_a(32'd1, 32'd2, 32'd3, 32'd4);
        beat_a(32'd1, 32'hDEAD);
        check("t1_busy_k0", a_busy, 32'd1);
        check("t1_ov_k0", a_out_valid, 32'd0);
        beat_a(32'd3, 32'd2);
        beat_a(32'hBEEF, 32'd4);
        a_in_valid = 1'b0;
        check("t1_ov_full", a_out_valid, 32'd1);
        check("t1_inrdy_full", a_in_ready, 32'd0);
        check("t1_busy_full", a_busy, 32'd0);
        tick();
        check("t1_ov_after", a_out_valid, 32'd0);
        check("t1_inrdy_after", a_in_ready, 32'd1);

        // 2: two bubble cycles between beats 0 and 1
        expect_a(32'd1, 32'd2, 32'd3, 32'd4);
        beat_a(32'd1, 32'hDEAD);
        a_in_valid = 1'b0;
        tick();
        check("t2_busy_stall1", a_busy, 32'd1);
        tick();
        check("t2_busy_stall2", a_busy, 32'd1);
        beat_a(32'd3, 32'd2);
        check("t2_busy_k1", a_busy, 32'd1);
        beat_a(32'hBEEF, 32'd4);
        a_in_valid = 1'b0;
        check("t2_ov_full", a_out_valid, 32'd1);
`ifdef COLLECT_STALL_COUNT_EN
        check("t2_stall_count", a_stall, 32'd2);
`endif
        tick();

        // 3: consumer stalls while new data (99) is offered
        a_out_ready = 1'b0;
        expect_a(32'd11, 32'd12, 32'd13, 32'd14);
        beat_a(32'd11, 32'hDEAD);
        beat_a(32'd13, 32'd12);
        beat_a(32'hBEEF, 32'd14);
        a_in_valid = 1'b1;
        a_in_data[0] = 32'd99;
        a_in_data[1] = 32'd99;
        for (int i = 0; i < 5; i++) begin
            check("t3_ov_hold", a_out_valid, 32'd1);
            check("t3_inrdy_hold", a_in_ready, 32'd0);
            check_mat_a("t3_hold", 32'd11, 32'd12, 32'd13, 32'd14);
            tick();
        end
        a_out_ready = 1'b1;
        tick();
        check("t3_ov_released", a_out_valid, 32'd0);
        check("t3_inrdy_idle", a_in_ready, 32'd1);
        expect_a(32'd99, 32'd97, 32'd96, 32'd95);
        beat_a(32'd99, 32'd99);
        check("t3_busy_next", a_busy, 32'd1);
        check("t3_new_c00", a_mat[0][0], 32'd99);
        beat_a(32'd96, 32'd97);
        beat_a(32'hBEEF, 32'd95);
        a_in_valid = 1'b0;
        check("t3_ov_second", a_out_valid, 32'd1);
`ifdef COLLECT_STALL_COUNT_EN
        check("t3_stall_count", a_stall, 32'd0);
`endif
        tick();

        // 4: reset in the middle of a capture, with a beat offered during reset
        beat_a(32'd21, 32'hDEAD);
        rst_n = 1'b0;
        beat_a(32'd23, 32'd22);
        check("t4_ov_rst", a_out_valid, 32'd0);
        check("t4_busy_rst", a_busy, 32'd0);
        check("t4_inrdy_rst", a_in_ready, 32'd1);
        check_mat_a("t4_rst", 32'd0, 32'd0, 32'd0, 32'd0);
`ifdef COLLECT_STALL_COUNT_EN
        check("t4_stall_rst", a_stall, 32'd0);
`endif
        rst_n = 1'b1;
        a_in_valid = 1'b0;
        expect_a(32'd5, 32'd6, 32'd7, 32'd8);
        beat_a(32'd5, 32'hDEAD);
        beat_a(32'd7, 32'd6);
        beat_a(32'hBEEF, 32'd8);
        a_in_valid = 1'b0;
        check("t4_ov_full", a_out_valid, 32'd1);
        tick();
        check("sb_drained", exp_q.size(), 32'd0);

        // 5a: ROWS=3, COLS=1
        b_in_valid = 1'b1;
        b_in_data[0] = 32'd10;
        tick();
        check("b_busy", b_busy, 32'd1);
        b_in_data[0] = 32'd11;
        tick();
        b_in_data[0] = 32'd12;
        tick();
        b_in_valid = 1'b0;
        check("b_ov", b_out_valid, 32'd1);
        check("b_inrdy_full", b_in_ready, 32'd0);
        check("b_r0", b_mat[0][0], 32'd10);
        check("b_r1", b_mat[1][0], 32'd11);
        check("b_r2", b_mat[2][0], 32'd12);
        tick();
        check("b_ov_after", b_out_valid, 32'd0);

        // 5b: ROWS=COLS=1
        c_in_valid = 1'b1;
        c_in_data[0] = 32'd42;
        tick();
        c_in_valid = 1'b0;
        check("c_ov", c_out_valid, 32'd1);
        check("c_inrdy_full", c_in_ready, 32'd0);
        check("c_busy", c_busy, 32'd0);
        check("c_m00", c_mat[0][0], 32'd42);
        tick();
        check("c_ov_after", c_out_valid, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
